mem_arbiter: RTL and testbench

Single-port memory arbiter for the ad100 core. Shares one synchronous word-wide memory between the instruction-fetch path (port 0) and the load/store path (port 1), issuing at most one access per cycle. Data accesses have priority; an optional starvation guard forces a fetch grant after a bounded run of data grants. Sits between `cpu` and the unified program/data memory inside `ad100`.

---
 rtl/ad1xx_pkg.sv | 6 +
 rtl/mem_arbiter.sv | 94 +++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ad1xx_pkg.sv
// Shared types and widths for the ad1xx memory arbiter.
package ad1xx_pkg;
  typedef enum logic {PORT_IF, PORT_D} arb_port_t;
  localparam int WORD_W = 32;
  localparam int STRB_W = 4;
endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data port has priority over instruction fetch.
// Define AD1XX_ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_LIMIT data grants.
module mem_arbiter
  import ad1xx_pkg::*;
#(
  parameter int ADDR_W       = 30,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [WORD_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [WORD_W-1:0] d_rdata,
  input  logic              mem_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic [WORD_W-1:0] mem_rdata
);

  logic      grant_ok;
  logic      force_if;
  logic      resp_valid;
  arb_port_t resp_port;

  assign grant_ok = mem_ready & ~reset;

`ifdef AD1XX_ARB_STARVE_GUARD_EN
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign force_if = if_req & (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Counts data grants taken while a fetch is left waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   starve_cnt <= '0;
    else if (!if_req || if_gnt)  starve_cnt <= '0;
    else if (d_gnt && starve_cnt != CNT_W'(STARVE_LIMIT))
                                 starve_cnt <= starve_cnt + 1'b1;
  end
`else
  logic unused_limit;
  assign unused_limit = ^STARVE_LIMIT;
  assign force_if     = 1'b0;
`endif

  assign d_gnt  = grant_ok & d_req & ~force_if;
  assign if_gnt = grant_ok & if_req & ~d_gnt;
  assign mem_en = if_gnt | d_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_wstrb = d_we ? d_wstrb : '0;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  // Async clear drops any read still in flight when reset hits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_port  <= PORT_IF;
    end else begin
      resp_valid <= if_gnt | (d_gnt & ~d_we);
      resp_port  <= d_gnt ? PORT_D : PORT_IF;
    end
  end

  assign if_rvalid = resp_valid & (resp_port == PORT_IF);
  assign d_rvalid  = resp_valid & (resp_port == PORT_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_mem_arbiter;
  import ad1xx_pkg::*;

  localparam int ADDR_W = 30;
  localparam int LIMIT  = 4;

  logic              clk, reset;
  logic              if_req, if_gnt, if_rvalid;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              d_req, d_we, d_gnt, d_rvalid;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata, d_rdata;
  logic [3:0]        d_wstrb;
  logic              mem_ready, mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [3:0]        mem_wstrb;

  mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_ready(mem_ready), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] init_word(int i);
    if (i == 4)  return 32'h1234_5678;
    if (i == 64) return 32'h0;
    return 32'(i) * 32'h9E37_79B9;
  endfunction

  // Memory environment, driven only by the DUT's mem_* outputs.
  logic [31:0] env_mem [512];
  bit          env_init = 1'b0;
  int          acc_cnt  = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      if (!env_init) begin
        for (int i = 0; i < 512; i++) env_mem[i] <= init_word(i);
        env_init <= 1'b1;
      end
    end else if (mem_en) begin
      acc_cnt <= acc_cnt + 1;
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) env_mem[mem_addr[8:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= env_mem[mem_addr[8:0]];
      end
    end
  end

  // Reference model: expected grants from the request rules, expected data from a shadow memory.
  logic [31:0] ref_mem [512];
  bit          ref_init = 1'b0;
  int          m_run;
  logic        m_rv;
  arb_port_t   m_port;
  logic [31:0] m_data;
  logic        exp_d, exp_i, m_force;

  always_comb begin
    m_force = 1'b0;
`ifdef AD1XX_ARB_STARVE_GUARD_EN
    m_force = if_req && (m_run >= LIMIT);
`endif
    exp_d = mem_ready && !reset && d_req && !m_force;
    exp_i = mem_ready && !reset && if_req && !exp_d;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rv   <= 1'b0;
      m_port <= PORT_IF;
      m_run  <= 0;
      if (!ref_init) begin
        for (int i = 0; i < 512; i++) ref_mem[i] <= init_word(i);
        ref_init <= 1'b1;
      end
    end else begin
      m_rv   <= exp_i || (exp_d && !d_we);
      m_port <= exp_d ? PORT_D : PORT_IF;
      m_data <= ref_mem[exp_d ? d_addr[8:0] : if_addr[8:0]];
      if (exp_d && d_we)
        for (int b = 0; b < 4; b++)
          if (d_wstrb[b]) ref_mem[d_addr[8:0]][8*b +: 8] <= d_wdata[8*b +: 8];
      if (!if_req || exp_i) m_run <= 0;
      else if (exp_d)       m_run <= m_run + 1;
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("if_gnt", if_gnt, exp_i);
      chk("d_gnt", d_gnt, exp_d);
      chk("one_gnt", if_gnt & d_gnt, 0);
      chk("mem_en", mem_en, exp_i | exp_d);
      chk("mem_we", mem_we, exp_d && d_we);
      chk("mem_wstrb", mem_wstrb, (exp_d && d_we) ? d_wstrb : 4'h0);
      if (exp_d)      chk("mem_addr_d", mem_addr, d_addr);
      else if (exp_i) chk("mem_addr_if", mem_addr, if_addr);
      if (exp_d && d_we) chk("mem_wdata", mem_wdata, d_wdata);
      chk("if_rvalid", if_rvalid, m_rv && m_port == PORT_IF);
      chk("d_rvalid", d_rvalid, m_rv && m_port == PORT_D);
      if (m_rv && m_port == PORT_D)  chk("d_rdata", d_rdata, m_data);
      if (m_rv && m_port == PORT_IF) chk("if_rdata", if_rdata, m_data);
    end
  end

  logic d_gnt_q = 1'b0, if_gnt_q = 1'b0;
  always @(posedge clk) begin
    d_gnt_q  <= d_gnt;
    if_gnt_q <= if_gnt;
  end

  task automatic idle();
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b1;
  endtask

  int ng_d, ng_i, a0;

  initial begin
    reset = 1'b0; mem_ready = 1'b1; mem_rdata = '0;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_wstrb = '0;
    #1 reset = 1'b1;

    // Requests during reset must not be granted.
    @(negedge clk);
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'hF;
    #2;
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_rvalid", {if_rvalid, d_rvalid}, 0);
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle();

    // Fetch only.
    @(negedge clk);
    if_req = 1'b1; if_addr = ADDR_W'(4);
    #2;
    chk("fo_gnt", if_gnt, 1);
    chk("fo_addr", mem_addr, 4);
    @(negedge clk);
    if_req = 1'b0;
    #2;
    chk("fo_rvalid", if_rvalid, 1);
    chk("fo_rdata", if_rdata, 32'h1234_5678);

    // Contention: data first, fetch next cycle.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = ADDR_W'('h100);
    if_req = 1'b1; if_addr = ADDR_W'(8);
    #2;
    chk("ct_d_gnt", d_gnt, 1);
    chk("ct_if_wait", if_gnt, 0);
    chk("ct_addr", mem_addr, 'h100);
    @(negedge clk);
    d_req = 1'b0;
    #2;
    chk("ct_d_rvalid", d_rvalid, 1);
    chk("ct_if_gnt", if_gnt, 1);
    @(negedge clk);
    if_req = 1'b0;
    #2;
    chk("ct_if_rvalid", if_rvalid, 1);
    chk("ct_if_rdata", if_rdata, init_word(8));

    // Partial write then read back.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = ADDR_W'('h40);
    d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
    #2;
    chk("wr_gnt", d_gnt, 1);
    chk("wr_we", mem_we, 1);
    chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("wr_wstrb", mem_wstrb, 4'b0011);
    @(negedge clk);
    d_we = 1'b0;
    #2;
    chk("wr_no_rvalid", d_rvalid, 0);
    chk("rd_gnt", d_gnt, 1);
    @(negedge clk);
    d_req = 1'b0;
    #2;
    chk("rd_rvalid", d_rvalid, 1);
    chk("rd_rdata", d_rdata, 32'h0000_BEEF);

    // Backpressure: three stalled cycles, then exactly one access.
    idle();
    a0 = acc_cnt;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_ready = 1'b0; if_req = 1'b1; if_addr = ADDR_W'(9);
      #2;
      chk("bp_stall", if_gnt, 0);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #2;
    chk("bp_gnt", if_gnt, 1);
    @(negedge clk);
    if_req = 1'b0;
    #2;
    chk("bp_rvalid", if_rvalid, 1);
    chk("bp_accesses", acc_cnt - a0, 1);

    // Continuous data traffic with a waiting fetch.
    idle();
    ng_d = 0; ng_i = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = ADDR_W'(3);
      if_req = 1'b1; if_addr = ADDR_W'(8);
      #2;
      ng_d += int'(d_gnt);
      ng_i += int'(if_gnt);
    end
`ifdef AD1XX_ARB_STARVE_GUARD_EN
    chk("sv_d_cnt", ng_d, 8);
    chk("sv_if_cnt", ng_i, 2);
`else
    chk("sv_d_cnt", ng_d, 10);
    chk("sv_if_cnt", ng_i, 0);
`endif
    idle();
    idle();

    // Reset lands while a read is in flight.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = ADDR_W'(5);
    #2;
    chk("mr_gnt", d_gnt, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("mr_drop", d_rvalid, 0);
    @(negedge clk);
    if_req = 1'b1;
    #2;
    chk("mr_rst_out", {if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid}, 0);
    chk("mr_rst_strb", mem_wstrb, 0);
    @(negedge clk);
    reset = 1'b0; if_req = 1'b0; d_addr = ADDR_W'(6);
    #2;
    chk("mr_post_gnt", d_gnt, 1);
    chk("mr_post_rv", d_rvalid, 0);
    @(negedge clk);
    d_req = 1'b0;
    #2;
    chk("mr_post_data", d_rdata, init_word(6));
    idle();

    // Randomized traffic with requesters honouring the hold rule.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      mem_ready = ($urandom_range(0, 9) < 8);
      if (!d_req || d_gnt_q) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = ADDR_W'($urandom_range(0, 31));
        d_wdata = $urandom;
        d_wstrb = 4'($urandom_range(0, 15));
      end
      if (!if_req || if_gnt_q) begin
        if_req  = 1'($urandom_range(0, 1));
        if_addr = ADDR_W'($urandom_range(0, 31));
      end
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
